// File: rtl/btn_move_conditioner.sv
// Button conditioner: sync, debounce, edge detect and typematic move commands.
// Ports: clk, rst, btn_raw[5] in; btn_level/btn_press[5], reset_req, move_valid/move_dir[4] out; move_ready in.
module btn_move_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000,
  parameter int CNT_W           = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_raw,
  output logic [4:0] btn_level,
  output logic [4:0] btn_press,
  output logic       reset_req,
  output logic       move_valid,
  output logic [3:0] move_dir,
  input  logic       move_ready
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } state_t;

  logic [4:0]       s1;
  logic [4:0]       s2;
  logic [4:0]       level_d;
  logic [4:0]       rise;
  logic [CNT_W-1:0] db_cnt [5];
  logic [3:0]       dir_req;

  state_t           state, state_n;
  logic [CNT_W-1:0] rpt_cnt, rpt_n;
  logic [3:0]       cur_dir, cur_n;
  logic             issue;
  logic [3:0]       issue_dir;
  logic             valid_n;
  logic [3:0]       dir_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // Any sample agreeing with the stable level restarts the count,
  // so only an uninterrupted run of DEBOUNCE_CYCLES is accepted.
  for (genvar i = 0; i < 5; i++) begin : g_db
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_cnt[i]    <= '0;
        btn_level[i] <= 1'b0;
      end else if (s2[i] == btn_level[i]) begin
        db_cnt[i] <= '0;
      end else if (db_cnt[i] == DB_LAST) begin
        db_cnt[i]    <= '0;
        btn_level[i] <= s2[i];
      end else begin
        db_cnt[i] <= db_cnt[i] + 1'b1;
      end
    end
  end

  assign rise = btn_level & ~level_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d   <= '0;
      btn_press <= '0;
    end else begin
      level_d   <= btn_level;
      btn_press <= rise;
    end
  end

  assign reset_req = btn_press[0];

  // Chords (or nothing) yield no direction.
  assign dir_req = $onehot(btn_level[4:1]) ? btn_level[4:1] : 4'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rpt_cnt    <= '0;
      cur_dir    <= '0;
      move_valid <= 1'b0;
      move_dir   <= '0;
    end else begin
      state      <= state_n;
      rpt_cnt    <= rpt_n;
      cur_dir    <= cur_n;
      move_valid <= valid_n;
      move_dir   <= dir_n;
    end
  end

  always_comb begin
    state_n   = state;
    rpt_n     = rpt_cnt;
    cur_n     = cur_dir;
    issue     = 1'b0;
    issue_dir = cur_dir;
    valid_n   = move_valid;
    dir_n     = move_dir;

    unique case (state)
      IDLE: begin
        if (dir_req != 4'b0) begin
          issue     = 1'b1;
          issue_dir = dir_req;
          cur_n     = dir_req;
          rpt_n     = '0;
          state_n   = DELAY;
        end
      end
      DELAY: begin
        if (dir_req != cur_dir) begin
          rpt_n   = '0;
          state_n = IDLE;
        end else if (rpt_cnt == RD_LAST) begin
          issue   = 1'b1;
          rpt_n   = '0;
          state_n = REPEAT;
        end else begin
          rpt_n = rpt_cnt + 1'b1;
        end
      end
      REPEAT: begin
        if (dir_req != cur_dir) begin
          rpt_n   = '0;
          state_n = IDLE;
        end else if (rpt_cnt == RP_LAST) begin
          issue = 1'b1;
          rpt_n = '0;
        end else begin
          rpt_n = rpt_cnt + 1'b1;
        end
      end
      default: begin
        rpt_n   = '0;
        state_n = IDLE;
      end
    endcase

    // Restart beats accept, accept beats a new issue; a pending move
    // swallows any issue, so repeats never pile up.
    if (rise[0]) begin
      valid_n = 1'b0;
      dir_n   = '0;
      state_n = IDLE;
      rpt_n   = '0;
    end else if (move_valid && move_ready) begin
      valid_n = 1'b0;
      dir_n   = '0;
    end else if (issue && !move_valid) begin
      valid_n = 1'b1;
      dir_n   = issue_dir;
    end
  end

endmodule
